// File: rtl/prpg_pkg.sv
// Shared opcode/state enums and constants for the PRPG engine.
package prpg_pkg;

    typedef enum logic [3:0] {
        OP_CFG_TAP   = 4'd0,
        OP_INIT_L    = 4'd1,
        OP_CFG_RULE  = 4'd2,
        OP_INIT_C    = 4'd3,
        OP_SET_ADDR  = 4'd4,
        OP_ADD_ADDR  = 4'd5,
        OP_RUN_L     = 4'd6,
        OP_RUN_C     = 4'd7,
        OP_BATCH_L   = 4'd8,
        OP_BATCH_C   = 4'd9,
        OP_ST_L      = 4'd10,
        OP_ST_C      = 4'd11,
        OP_CLR_STATS = 4'd12,
        OP_HALT      = 4'd13
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BATCH,
        S_HALT
    } state_e;

    localparam int HD_SUM_W = 16;

endpackage

// File: rtl/prpg_step.sv
// Combinational next-state logic: Galois LFSR step, cyclic CA step, and
// Hamming distance between the current and next LFSR states.
module prpg_step #(
    parameter int W = 8
) (
    input  logic [W-1:0]           lfsr_q,
    input  logic [W-2:0]           tap,
    input  logic [W-1:0]           ca_q,
    input  logic [7:0]             rule,
    output logic [W-1:0]           lfsr_next,
    output logic [W-1:0]           ca_next,
    output logic [$clog2(W+1)-1:0] hd
);

    localparam int HW = $clog2(W+1);

    logic [W-1:0] diff;
    logic [2:0]   nb;

    always_comb begin
        lfsr_next    = '0;
        lfsr_next[0] = lfsr_q[W-1];
        for (int unsigned k = 0; k < W - 1; k++) begin
            lfsr_next[k+1] = lfsr_q[k] ^ (tap[k] & lfsr_q[W-1]);
        end
    end

    // Neighbourhood index is {right, self, left} with wrap-around at both ends.
    always_comb begin
        ca_next = '0;
        nb      = '0;
        for (int unsigned i = 0; i < W; i++) begin
            nb         = {ca_q[(i + 1) % W], ca_q[i], ca_q[(i + W - 1) % W]};
            ca_next[i] = rule[nb];
        end
    end

    always_comb begin
        diff = lfsr_q ^ lfsr_next;
        hd   = '0;
        for (int unsigned i = 0; i < W; i++) begin
            hd = hd + {{(HW-1){1'b0}}, diff[i]};
        end
    end

endmodule

// File: rtl/prpg_engine.sv
// PRPG engine top: command decoder, run/batch FSM and pattern-RAM write port.
// Optional Hamming statistics are enabled by defining PRPG_HD_STATS_EN.
module prpg_engine
    import prpg_pkg::*;
#(
    parameter int W     = 8,
    parameter int AW    = 8,
    parameter int ARG_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_op,
    input  logic [ARG_W-1:0]       cmd_arg,
    output logic                   busy,
    output logic                   done,
    output logic                   halted,
    output logic [W-1:0]           lfsr_q,
    output logic [W-1:0]           ca_q,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [W-1:0]           mem_wdata,
    output logic [$clog2(W+1)-1:0] hd_last,
    output logic [HD_SUM_W-1:0]    hd_sum,
    output logic [HD_SUM_W-1:0]    step_cnt
);

    localparam int HW = $clog2(W+1);

    state_e           state;
    op_e              op;
    logic [W-2:0]     tap;
    logic [7:0]       rule;
    logic [W-1:0]     lfsr;
    logic [W-1:0]     ca;
    logic [AW-1:0]    addr;
    logic [ARG_W-1:0] cnt;
    logic             sel_ca;
    logic [W-1:0]     lfsr_next;
    logic [W-1:0]     ca_next;

`ifdef PRPG_HD_STATS_EN
    logic [HW-1:0] hd;
`else
    logic [HW-1:0] hd_unused;
`endif

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN) || (state == S_BATCH);
    assign halted    = (state == S_HALT);
    assign lfsr_q    = lfsr;
    assign ca_q      = ca;

    prpg_step #(
        .W (W)
    ) u_step (
        .lfsr_q    (lfsr),
        .tap       (tap),
        .ca_q      (ca),
        .rule      (rule),
        .lfsr_next (lfsr_next),
        .ca_next   (ca_next),
`ifdef PRPG_HD_STATS_EN
        .hd        (hd)
`else
        .hd        (hd_unused)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tap       <= '0;
            rule      <= '0;
            lfsr      <= '0;
            ca        <= '0;
            addr      <= '0;
            cnt       <= '0;
            sel_ca    <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        done <= 1'b1;
                        case (op)
                            OP_CFG_TAP:  tap  <= cmd_arg[W-2:0];
                            OP_INIT_L:   lfsr <= cmd_arg[W-1:0];
                            OP_CFG_RULE: rule <= cmd_arg[7:0];
                            OP_INIT_C:   ca   <= cmd_arg[W-1:0];
                            OP_SET_ADDR: addr <= cmd_arg[AW-1:0];
                            OP_ADD_ADDR: addr <= addr + cmd_arg[AW-1:0];
                            OP_RUN_L, OP_RUN_C, OP_BATCH_L, OP_BATCH_C: begin
                                sel_ca <= (op == OP_RUN_C) || (op == OP_BATCH_C);
                                // A zero count completes immediately without stepping.
                                if (cmd_arg != '0) begin
                                    done  <= 1'b0;
                                    cnt   <= cmd_arg;
                                    state <= ((op == OP_BATCH_L) || (op == OP_BATCH_C))
                                             ? S_BATCH : S_RUN;
                                end
                            end
                            OP_ST_L: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= lfsr;
                            end
                            OP_ST_C: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= ca;
                            end
                            OP_HALT: state <= S_HALT;
                            default: ;
                        endcase
                    end
                end
                S_RUN, S_BATCH: begin
                    if (sel_ca) ca <= ca_next;
                    else        lfsr <= lfsr_next;
                    if (state == S_BATCH) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= sel_ca ? ca_next : lfsr_next;
                        addr      <= addr + AW'(1);
                    end
                    cnt <= cnt - ARG_W'(1);
                    if (cnt == ARG_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PRPG_HD_STATS_EN
    localparam int SW1 = HD_SUM_W + 1;

    logic           lfsr_adv;
    logic           clr;
    logic [SW1-1:0] sum_ext;

    assign lfsr_adv = busy && !sel_ca;
    assign clr      = (state == S_IDLE) && cmd_valid && (op == OP_CLR_STATS);
    assign sum_ext  = {1'b0, hd_sum} + SW1'(hd);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hd_last  <= '0;
            hd_sum   <= '0;
            step_cnt <= '0;
        end else if (lfsr_adv) begin
            hd_last  <= hd;
            hd_sum   <= sum_ext[HD_SUM_W] ? '1 : sum_ext[HD_SUM_W-1:0];
            if (step_cnt != '1) step_cnt <= step_cnt + HD_SUM_W'(1);
        end
    end
`else
    assign hd_last  = '0;
    assign hd_sum   = '0;
    assign step_cnt = '0;
`endif

endmodule
